rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//   Shares the single register-file write port (kind/A3/WD) among NREQ writeback requesters
//   (0 = ALU, 1 = load unit, 2 = debug/host) using round-robin arbitration.
//   Granted writes are queued in a DEPTH-entry FIFO, which drains one write per clk into the RF.
//   A read-hazard check stalls the decode stage while a pending write targets a source register.
//   Sits between the execute/memory/debug units and the RF.
// PARAMETERS
//   NREQ   3   number of writeback requesters (2..4)
//   DEPTH  4   write-queue entries (power of 2, >=2)
//   AW     5   register address width
//   DW     32  data width
// PORTS
//   clk          in   1          clock
//   rst          in   1          reset, asynchronous, active-low
//   req_valid    in   NREQ       requester i has a write pending
//   req_ready    out  NREQ       requester i accepted this cycle (one-hot or zero)
//   req_kind     in   3*NREQ     RF write kind: 001 lw, 010 lh, 011 lb, 100 lhu, 101 lbu
//   req_addr     in   AW*NREQ    destination register
//   req_data     in   DW*NREQ    unextended write data
//   rf_hold      in   1          freeze the drain (debug single-step)
//   rd_a1        in   AW         decode-stage source 1
//   rd_a2        in   AW         decode-stage source 2
//   rf_wr_kind   out  3          to RF RFWr; 000 = no write
//   rf_wr_addr   out  AW         to RF A3
//   rf_wr_data   out  DW         to RF WD
//   hazard       out  1          stall decode
//   q_count      out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//   Reset: FIFO empty, rd/wr pointers 0, round-robin pointer 0, rf_wr_kind=000,
//     rf_wr_addr=0, rf_wr_data=0, req_ready=0, hazard=0, q_count=0.
//     A mid-operation reset discards every queued write.
//   Handshake: a requester holds valid/kind/addr/data stable until ready.
//     Transfer = valid & ready at the posedge.
//   Arbitration: round-robin, starting at rr_ptr.
//     The first valid requester in cyclic order from rr_ptr is granted when can_push.
//     can_push = (q_count < DEPTH) | pop. A push and pop in the same cycle is legal when full.
//     After a grant to requester g: rr_ptr <= (g+1) mod NREQ. With no grant, rr_ptr holds.
//   Drop rule: a request with addr==0 or kind in {000,110,111} is accepted (ready=1)
//     but not pushed, and consumes the grant.
//   Drain: head is valid when q_count!=0. pop = head_valid & ~rf_hold.
//     rf_wr_* is driven combinationally from the head when pop=1; otherwise kind=000.
//     The RF samples on the negedge inside the same cycle, and the entry leaves at the next posedge.
//   Latency: a request accepted at posedge N reaches rf_wr_* in cycle N+1 when the queue was empty,
//     is committed to the RF at the negedge of cycle N+1, and is readable from cycle N+2.
//   Ordering: FIFO order is preserved, so two writes to the same register commit in grant order.
//   Hazard: hazard=1 when rd_aX!=0 matches the addr of any occupied FIFO entry or any req_valid
//     (non-dropped) request. r0 never hazards. The result is combinational.
//   Widths: q_count spans 0..DEPTH. Pointers wrap mod DEPTH. No extension is done here; the RF extends by kind.
//   rf_hold=1 with a full queue: all req_ready=0 and the requesters stall. No entry is lost.
// STRUCTURE
//   Shared package rf_pkg: RF_KIND_{NONE,LW,LH,LB,LHU,LBU} localparams, RF_AW, RF_DW.
//   Sub-module rr_arbiter(NREQ): req, enable -> one-hot grant, and an rr_ptr register.
//   The FIFO storage and hazard compare stay inline.
// TESTING
//   1. Reset with req_valid=111 held, then release: ALU grant first. Grants go 0,1,2,0 in
//      successive cycles, and rf_wr_kind is nonzero from cycle 2.
//   2. Single ALU lw r5=0xDEADBEEF: rf_wr_kind=001, addr=5, data=0xDEADBEEF appear for one cycle.
//      hazard=1 for rd_a1=5 until the entry pops.
//   3. rf_hold=1 with 5 requests: q_count reaches 4, then ready=0. Release hold: 4 pops then 1,
//      in FIFO order.
//   4. Full queue with hold=0 and a new request: push and pop in the same cycle, q_count stays 4.
//   5. Write to r0 and a kind=110 request: both accepted, nothing written, hazard=0 for rd_a1=0.
//   6. Assert rst low with 3 entries queued: next cycle q_count=0, rf_wr_kind=000, and no stale
//      write appears after release.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file write definitions: write-kind encodings and RF port widths.
package rf_pkg;

    localparam int RF_AW = 5;
    localparam int RF_DW = 32;

    localparam logic [2:0] RF_KIND_NONE = 3'b000;
    localparam logic [2:0] RF_KIND_LW   = 3'b001;
    localparam logic [2:0] RF_KIND_LH   = 3'b010;
    localparam logic [2:0] RF_KIND_LB   = 3'b011;
    localparam logic [2:0] RF_KIND_LHU  = 3'b100;
    localparam logic [2:0] RF_KIND_LBU  = 3'b101;

    function automatic logic rf_kind_valid(input logic [2:0] kind);
        case (kind)
            RF_KIND_LW, RF_KIND_LH, RF_KIND_LB, RF_KIND_LHU, RF_KIND_LBU: return 1'b1;
            default:                                                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the rotating pointer.
module rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_i,
    input  logic            en_i,
    output logic [NREQ-1:0] grant_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] idx_s;
    logic          found_s;

    // Scan requesters in cyclic order from the pointer; the winner's successor becomes the new pointer.
    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        found_s = 1'b0;
        idx_s   = '0;
        for (int off = 0; off < NREQ; off++) begin
            idx_s = PW'((int'(ptr_q) + off) % NREQ);
            if (en_i && !found_s && req_i[idx_s]) begin
                found_s        = 1'b1;
                grant_o[idx_s] = 1'b1;
                ptr_d          = PW'((int'(idx_s) + 1) % NREQ);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin grant into a write FIFO that drains one write per
// cycle to the RF write port, plus a decode-stage read-after-write hazard check.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int DEPTH = 4,
    parameter int AW    = RF_AW,
    parameter int DW    = RF_DW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [3*NREQ-1:0]          req_kind,
    input  logic [AW*NREQ-1:0]         req_addr,
    input  logic [DW*NREQ-1:0]         req_data,
    input  logic                       rf_hold,
    input  logic [AW-1:0]              rd_a1,
    input  logic [AW-1:0]              rd_a2,
    output logic [2:0]                 rf_wr_kind,
    output logic [AW-1:0]              rf_wr_addr,
    output logic [DW-1:0]              rf_wr_data,
    output logic                       hazard,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [2:0]      kind_q [DEPTH];
    logic [AW-1:0]   addr_q [DEPTH];
    logic [DW-1:0]   data_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [NREQ-1:0] drop_s;
    logic [NREQ-1:0] grant_s;
    logic            pop_s;
    logic            can_push_s;
    logic            push_s;
    logic [2:0]      g_kind_s;
    logic [AW-1:0]   g_addr_s;
    logic [DW-1:0]   g_data_s;
    logic [PW-1:0]   off_s;
    logic            hz_s;

    function automatic logic src_match(input logic [AW-1:0] a, input logic [AW-1:0] s1,
                                       input logic [AW-1:0] s2);
        return (a != '0) && ((a == s1) || (a == s2));
    endfunction

    assign pop_s      = (count_q != '0) & ~rf_hold;
    assign can_push_s = (count_q < CW'(DEPTH)) | pop_s;

    // Writes to r0 or with an unknown kind are acknowledged but never queued.
    always_comb begin
        drop_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            drop_s[i] = (req_addr[AW*i +: AW] == '0) | ~rf_kind_valid(req_kind[3*i +: 3]);
        end
    end

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk     (clk),
        .rst_n   (rst),
        .req_i   (req_valid),
        .en_i    (can_push_s & rst),
        .grant_o (grant_s)
    );

    assign req_ready = grant_s;
    assign push_s    = |(grant_s & ~drop_s);

    // Select the granted requester's payload.
    always_comb begin
        g_kind_s = '0;
        g_addr_s = '0;
        g_data_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_s[i]) begin
                g_kind_s = req_kind[3*i +: 3];
                g_addr_s = req_addr[AW*i +: AW];
                g_data_s = req_data[DW*i +: DW];
            end else begin
                g_kind_s = g_kind_s;
            end
        end
    end

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_s) - CW'(pop_s);
    end

    // RF sees the head only in cycles where it actually leaves the queue.
    always_comb begin
        if (pop_s) begin
            rf_wr_kind = kind_q[rd_ptr_q];
            rf_wr_addr = addr_q[rd_ptr_q];
            rf_wr_data = data_q[rd_ptr_q];
        end else begin
            rf_wr_kind = RF_KIND_NONE;
            rf_wr_addr = '0;
            rf_wr_data = '0;
        end
    end

    // Hazard: any occupied entry or live non-dropped request targeting a decode source.
    always_comb begin
        hz_s  = 1'b0;
        off_s = '0;
        for (int j = 0; j < DEPTH; j++) begin
            off_s = PW'(j) - rd_ptr_q;
            if ((CW'(off_s) < count_q) && src_match(addr_q[j], rd_a1, rd_a2)) begin
                hz_s = 1'b1;
            end else begin
                hz_s = hz_s;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && !drop_s[i] && src_match(req_addr[AW*i +: AW], rd_a1, rd_a2)) begin
                hz_s = 1'b1;
            end else begin
                hz_s = hz_s;
            end
        end
    end

    assign hazard  = hz_s & rst;
    assign q_count = count_q;

    // Queue control registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < DEPTH; j++) begin
                kind_q[j] <= RF_KIND_NONE;
                addr_q[j] <= '0;
                data_q[j] <= '0;
            end
        end else if (push_s) begin
            kind_q[wr_ptr_q] <= g_kind_s;
            addr_q[wr_ptr_q] <= g_addr_s;
            data_q[wr_ptr_q] <= g_data_s;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (NREQ=3, DEPTH=4, AW=5, DW=32).
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [8:0]  req_kind;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic        rf_hold;
    logic [4:0]  rd_a1;
    logic [4:0]  rd_a2;
    logic [2:0]  rf_wr_kind;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic        hazard;
    logic [2:0]  q_count;

    int n_cmp;
    int n_err;

    always #5 clk = ~clk;

    rf_wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_kind   (req_kind),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .rf_hold    (rf_hold),
        .rd_a1      (rd_a1),
        .rd_a2      (rd_a2),
        .rf_wr_kind (rf_wr_kind),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .hazard     (hazard),
        .q_count    (q_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] k, input logic [4:0] a, input logic [31:0] d);
        req_kind[3*i +: 3]  = k;
        req_addr[5*i +: 5]  = a;
        req_data[32*i +: 32] = d;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b0;
        rf_hold   = 1'b0;
        rd_a1     = 5'd0;
        rd_a2     = 5'd0;
        req_valid = 3'b000;
        req_kind  = 9'd0;
        req_addr  = 15'd0;
        req_data  = 96'd0;

        // 1: reset with all requesters valid, then round-robin 0,1,2,0
        set_req(0, 3'b001, 5'd1, 32'h1111_0001);
        set_req(1, 3'b010, 5'd2, 32'h2222_0002);
        set_req(2, 3'b011, 5'd3, 32'h3333_0003);
        req_valid = 3'b111;
        rd_a1     = 5'd1;
        step(); step(); #2;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_count", 32'(q_count), 32'h0);
        chk("rst_kind", 32'(rf_wr_kind), 32'h0);
        chk("rst_addr", 32'(rf_wr_addr), 32'h0);
        chk("rst_data", rf_wr_data, 32'h0);
        chk("rst_hazard", 32'(hazard), 32'h0);

        step(); rst = 1'b1; #2;
        chk("t1_c1_ready", 32'(req_ready), 32'h1);
        chk("t1_c1_kind", 32'(rf_wr_kind), 32'h0);

        step(); set_req(0, 3'b001, 5'd4, 32'h4444_0004); #2;
        chk("t1_c2_ready", 32'(req_ready), 32'h2);
        chk("t1_c2_kind", 32'(rf_wr_kind), 32'h1);
        chk("t1_c2_addr", 32'(rf_wr_addr), 32'd1);
        chk("t1_c2_data", rf_wr_data, 32'h1111_0001);

        step(); req_valid = 3'b101; #2;
        chk("t1_c3_ready", 32'(req_ready), 32'h4);
        chk("t1_c3_kind", 32'(rf_wr_kind), 32'h2);
        chk("t1_c3_addr", 32'(rf_wr_addr), 32'd2);

        step(); req_valid = 3'b001; #2;
        chk("t1_c4_ready", 32'(req_ready), 32'h1);
        chk("t1_c4_kind", 32'(rf_wr_kind), 32'h3);
        chk("t1_c4_addr", 32'(rf_wr_addr), 32'd3);

        step(); req_valid = 3'b000; rd_a1 = 5'd4; #2;
        chk("t1_c5_ready", 32'(req_ready), 32'h0);
        chk("t1_c5_kind", 32'(rf_wr_kind), 32'h1);
        chk("t1_c5_addr", 32'(rf_wr_addr), 32'd4);
        chk("t1_c5_hazard", 32'(hazard), 32'h1);
        chk("t1_c5_count", 32'(q_count), 32'd1);

        step(); #2;
        chk("t1_c6_kind", 32'(rf_wr_kind), 32'h0);
        chk("t1_c6_count", 32'(q_count), 32'd0);
        chk("t1_c6_hazard", 32'(hazard), 32'h0);

        // 2: single ALU lw r5
        step(); set_req(0, 3'b001, 5'd5, 32'hDEAD_BEEF); req_valid = 3'b001; rd_a1 = 5'd5; #2;
        chk("t2_ready", 32'(req_ready), 32'h1);
        chk("t2_hazard_req", 32'(hazard), 32'h1);
        step(); req_valid = 3'b000; #2;
        chk("t2_kind", 32'(rf_wr_kind), 32'h1);
        chk("t2_addr", 32'(rf_wr_addr), 32'd5);
        chk("t2_data", rf_wr_data, 32'hDEAD_BEEF);
        chk("t2_hazard_q", 32'(hazard), 32'h1);
        chk("t2_count", 32'(q_count), 32'd1);
        step(); #2;
        chk("t2_kind_after", 32'(rf_wr_kind), 32'h0);
        chk("t2_hazard_after", 32'(hazard), 32'h0);
        chk("t2_count_after", 32'(q_count), 32'd0);

        // 3+4: hold fills the queue, then push and pop together while full
        step(); rf_hold = 1'b1; rd_a1 = 5'd0; req_valid = 3'b010;
        for (int k = 0; k < 4; k++) begin
            set_req(1, 3'b100, 5'(6 + k), 32'hA000_0000 + 32'(k)); #2;
            chk("t3_fill_ready", 32'(req_ready), 32'h2);
            chk("t3_fill_count", 32'(q_count), 32'(k));
            chk("t3_fill_kind", 32'(rf_wr_kind), 32'h0);
            step();
        end
        set_req(1, 3'b100, 5'd10, 32'hA000_0004); #2;
        chk("t3_full_ready", 32'(req_ready), 32'h0);
        chk("t3_full_count", 32'(q_count), 32'd4);
        chk("t3_full_kind", 32'(rf_wr_kind), 32'h0);

        step(); rf_hold = 1'b0; #2;
        chk("t4_ready", 32'(req_ready), 32'h2);
        chk("t4_count", 32'(q_count), 32'd4);
        chk("t4_kind", 32'(rf_wr_kind), 32'h4);
        chk("t4_addr", 32'(rf_wr_addr), 32'd6);
        chk("t4_data", rf_wr_data, 32'hA000_0000);
        for (int k = 1; k <= 4; k++) begin
            step(); req_valid = 3'b000; #2;
            chk("t3_drain_kind", 32'(rf_wr_kind), 32'h4);
            chk("t3_drain_addr", 32'(rf_wr_addr), 32'(6 + k));
            chk("t3_drain_data", rf_wr_data, 32'hA000_0000 + 32'(k));
            chk("t3_drain_count", 32'(q_count), 32'(5 - k));
        end
        step(); #2;
        chk("t3_empty_kind", 32'(rf_wr_kind), 32'h0);
        chk("t3_empty_count", 32'(q_count), 32'd0);

        // 5: dropped requests (r0 target, kind 110)
        step(); set_req(0, 3'b001, 5'd0, 32'h5555_5555); req_valid = 3'b001; rd_a1 = 5'd0; #2;
        chk("t5_r0_ready", 32'(req_ready), 32'h1);
        chk("t5_r0_hazard", 32'(hazard), 32'h0);
        step(); set_req(2, 3'b110, 5'd7, 32'h7777_7777); req_valid = 3'b100; rd_a1 = 5'd7; #2;
        chk("t5_r0_count", 32'(q_count), 32'd0);
        chk("t5_r0_kind", 32'(rf_wr_kind), 32'h0);
        chk("t5_k6_ready", 32'(req_ready), 32'h4);
        chk("t5_k6_hazard", 32'(hazard), 32'h0);
        step(); req_valid = 3'b000; #2;
        chk("t5_k6_count", 32'(q_count), 32'd0);
        chk("t5_k6_kind", 32'(rf_wr_kind), 32'h0);

        // 6: mid-operation reset discards queued writes
        step(); rf_hold = 1'b1; rd_a1 = 5'd0;
        for (int k = 0; k < 3; k++) begin
            set_req(0, 3'b011, 5'(11 + k), 32'hC000_0000 + 32'(k));
            req_valid = 3'b001; #2;
            step();
        end
        req_valid = 3'b000; #2;
        chk("t6_pre_count", 32'(q_count), 32'd3);
        rd_a1 = 5'd12; #1;
        chk("t6_pre_hazard", 32'(hazard), 32'h1);
        rst = 1'b0; #1;
        chk("t6_rst_count", 32'(q_count), 32'd0);
        chk("t6_rst_kind", 32'(rf_wr_kind), 32'h0);
        chk("t6_rst_hazard", 32'(hazard), 32'h0);
        step(); #2;
        chk("t6_next_count", 32'(q_count), 32'd0);
        chk("t6_next_ready", 32'(req_ready), 32'h0);
        step(); rst = 1'b1; rf_hold = 1'b0; #2;
        for (int k = 0; k < 3; k++) begin
            chk("t6_stale_kind", 32'(rf_wr_kind), 32'h0);
            chk("t6_stale_count", 32'(q_count), 32'd0);
            step(); #2;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
